// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port and the IF/ID (PR1) outputs.
// The fetch stage uses the slave modport; the surrounding pipeline (or a bench) uses master.
interface if_stage_if #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 19,
  parameter int CNT_W   = 16
);
  logic               PC_write_en;
  logic               PR1_IF_ID_write_en;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] inst_mem_data;

  logic [PC_W-1:0]    inst_mem_addr;
  logic [INSTR_W-1:0] PR1_instruction;
  logic [PC_W-1:0]    PR1_PC_plus1;
  logic               PR1_valid;
  logic [4:0]         PR1_opcode;
  logic [2:0]         PR1_rd;
  logic [2:0]         PR1_rs;
  logic [2:0]         PR1_rt;
  logic [CNT_W-1:0]   stall_count;
  logic [CNT_W-1:0]   fetch_count;

  modport slave (
    input  PC_write_en, PR1_IF_ID_write_en, branch_taken, branch_target, inst_mem_data,
    output inst_mem_addr, PR1_instruction, PR1_PC_plus1, PR1_valid,
           PR1_opcode, PR1_rd, PR1_rs, PR1_rt, stall_count, fetch_count
  );

  modport master (
    output PC_write_en, PR1_IF_ID_write_en, branch_taken, branch_target, inst_mem_data,
    input  inst_mem_addr, PR1_instruction, PR1_PC_plus1, PR1_valid,
           PR1_opcode, PR1_rd, PR1_rs, PR1_rt, stall_count, fetch_count
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch + IF/ID register (PR1) for the 19-bit pipeline, with stall/redirect
// handling and saturating stall / retired-fetch counters.
module if_stage #(
  parameter int                 PC_W      = 12,
  parameter int                 INSTR_W   = 19,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 19'h0E000,
  parameter int                 CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  if_stage_if.slave   bus
);

  logic [PC_W-1:0]    pc_q, pc_d, pc_plus1;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pp1_q, pp1_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   fetch_q, fetch_d;
  logic               stall_evt, fetch_evt;

  always_comb begin
    pc_plus1  = pc_q + 1'b1;
    // A redirect cycle is never counted as a stall: the held instruction was wrong-path.
    stall_evt = !bus.PC_write_en && !bus.branch_taken;
    fetch_evt = bus.PR1_IF_ID_write_en && !bus.branch_taken;

    pc_d = pc_q;
    if (bus.branch_taken)     pc_d = bus.branch_target;
    else if (bus.PC_write_en) pc_d = pc_plus1;

    instr_d = instr_q;
    pp1_d   = pp1_q;
    valid_d = valid_q;
    if (bus.branch_taken) begin
      instr_d = NOP_INSTR;
      pp1_d   = '0;
      valid_d = 1'b0;
    end else if (bus.PR1_IF_ID_write_en) begin
      instr_d = bus.inst_mem_data;
      pp1_d   = pc_plus1;
      valid_d = 1'b1;
    end

    stall_d = stall_q;
    if (stall_evt && (stall_q != '1)) stall_d = stall_q + 1'b1;
    fetch_d = fetch_q;
    if (fetch_evt && (fetch_q != '1)) fetch_d = fetch_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      pp1_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
      fetch_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pp1_q   <= pp1_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      fetch_q <= fetch_d;
    end
  end

  assign bus.inst_mem_addr   = pc_q;
  assign bus.PR1_instruction = instr_q;
  assign bus.PR1_PC_plus1    = pp1_q;
  assign bus.PR1_valid       = valid_q;
  assign bus.PR1_opcode      = instr_q[18:14];
  assign bus.PR1_rd          = instr_q[13:11];
  assign bus.PR1_rs          = instr_q[10:8];
  assign bus.PR1_rt          = instr_q[7:5];
  assign bus.stall_count     = stall_q;
  assign bus.fetch_count     = fetch_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: directed steps push hand-computed post-edge state,
// a monitor pops and compares after each clock edge or reset assertion.
module tb_if_stage;
  localparam logic [18:0] NOP = 19'h0E000;

  typedef struct {
    int          id;
    logic [11:0] addr;
    logic [18:0] instr;
    logic [11:0] pp1;
    logic        v;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;
  int   step_id  = 0;
  exp_t exp_q[$];

  if_stage_if bus ();

  if_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Instruction memory: word n holds 19'h00100 + n.
  assign bus.inst_mem_data = 19'h00100 + {7'd0, bus.inst_mem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, req);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and queue the expected post-edge state.
  task automatic step(input logic r, input logic pcw, input logic prw, input logic br,
                      input logic [11:0] tgt, input logic [11:0] addr, input logic [18:0] instr,
                      input logic [11:0] pp1, input logic v, input logic [15:0] sc,
                      input logic [15:0] fc);
    exp_t e;
    @(negedge clk);
    rst                    = r;
    bus.PC_write_en        = pcw;
    bus.PR1_IF_ID_write_en = prw;
    bus.branch_taken       = br;
    bus.branch_target      = tgt;
    step_id++;
    e = '{step_id, addr, instr, pp1, v, sc, fc};
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [18:0] ei;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ei = e.instr;
        chk("inst_mem_addr", e.id, {20'd0, bus.inst_mem_addr}, {20'd0, e.addr});
        chk("PR1_instruction", e.id, {13'd0, bus.PR1_instruction}, {13'd0, ei});
        chk("PR1_PC_plus1", e.id, {20'd0, bus.PR1_PC_plus1}, {20'd0, e.pp1});
        chk("PR1_valid", e.id, {31'd0, bus.PR1_valid}, {31'd0, e.v});
        chk("PR1_opcode", e.id, {27'd0, bus.PR1_opcode}, {27'd0, ei[18:14]});
        chk("PR1_rd", e.id, {29'd0, bus.PR1_rd}, {29'd0, ei[13:11]});
        chk("PR1_rs", e.id, {29'd0, bus.PR1_rs}, {29'd0, ei[10:8]});
        chk("PR1_rt", e.id, {29'd0, bus.PR1_rt}, {29'd0, ei[7:5]});
        chk("stall_count", e.id, {16'd0, bus.stall_count}, {16'd0, e.sc});
        chk("fetch_count", e.id, {16'd0, bus.fetch_count}, {16'd0, e.fc});
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    exp_t e;
    rst                    = 1'b1;
    bus.PC_write_en        = 1'b0;
    bus.PR1_IF_ID_write_en = 1'b0;
    bus.branch_taken       = 1'b0;
    bus.branch_target      = '0;

    // Reset held: reset values visible.
    step(1, 1, 1, 0, 12'h000, 12'h000, NOP, 12'h000, 0, 16'd0, 16'd0);
    // Release and free-run: fetch from 0 upward.
    step(0, 1, 1, 0, 12'h000, 12'h001, 19'h00100, 12'h001, 1, 16'd0, 16'd1);
    step(0, 1, 1, 0, 12'h000, 12'h002, 19'h00101, 12'h002, 1, 16'd0, 16'd2);
    step(0, 1, 1, 0, 12'h000, 12'h003, 19'h00102, 12'h003, 1, 16'd0, 16'd3);
    step(0, 1, 1, 0, 12'h000, 12'h004, 19'h00103, 12'h004, 1, 16'd0, 16'd4);
    step(0, 1, 1, 0, 12'h000, 12'h005, 19'h00104, 12'h005, 1, 16'd0, 16'd5);
    // Two-cycle stall at PC=5, PR1 keeps the PC=4 instruction.
    step(0, 0, 0, 0, 12'h000, 12'h005, 19'h00104, 12'h005, 1, 16'd1, 16'd5);
    step(0, 0, 0, 0, 12'h000, 12'h005, 19'h00104, 12'h005, 1, 16'd2, 16'd5);
    step(0, 1, 1, 0, 12'h000, 12'h006, 19'h00105, 12'h006, 1, 16'd2, 16'd6);
    // Mismatched enables.
    step(0, 1, 0, 0, 12'h000, 12'h007, 19'h00105, 12'h006, 1, 16'd2, 16'd6);
    step(0, 0, 1, 0, 12'h000, 12'h007, 19'h00107, 12'h008, 1, 16'd3, 16'd7);
    // Redirect during a full stall: flush, counters untouched.
    step(0, 0, 0, 1, 12'h3A0, 12'h3A0, NOP, 12'h000, 0, 16'd3, 16'd7);
    step(0, 1, 1, 0, 12'h000, 12'h3A1, 19'h004A0, 12'h3A1, 1, 16'd3, 16'd8);
    // Redirect to the top address, then wrap.
    step(0, 1, 1, 1, 12'hFFF, 12'hFFF, NOP, 12'h000, 0, 16'd3, 16'd8);
    step(0, 1, 1, 0, 12'h000, 12'h000, 19'h010FF, 12'h000, 1, 16'd3, 16'd9);
    step(0, 1, 1, 0, 12'h000, 12'h001, 19'h00100, 12'h001, 1, 16'd3, 16'd10);
    step(0, 1, 1, 0, 12'h000, 12'h002, 19'h00101, 12'h002, 1, 16'd3, 16'd11);
    step(0, 1, 1, 0, 12'h000, 12'h003, 19'h00102, 12'h003, 1, 16'd3, 16'd12);
    step(0, 1, 1, 0, 12'h000, 12'h004, 19'h00103, 12'h004, 1, 16'd3, 16'd13);
    step(0, 1, 1, 0, 12'h000, 12'h005, 19'h00104, 12'h005, 1, 16'd3, 16'd14);
    step(0, 1, 1, 0, 12'h000, 12'h006, 19'h00105, 12'h006, 1, 16'd3, 16'd15);
    step(0, 1, 1, 0, 12'h000, 12'h007, 19'h00106, 12'h007, 1, 16'd3, 16'd16);
    step(0, 0, 0, 0, 12'h000, 12'h007, 19'h00106, 12'h007, 1, 16'd4, 16'd16);

    // Asynchronous reset mid-cycle during the stall: checked before the next edge.
    @(negedge clk);
    #2;
    step_id++;
    e = '{step_id, 12'h000, NOP, 12'h000, 1'b0, 16'd0, 16'd0};
    exp_q.push_back(e);
    rst = 1'b1;

    // Release: first fetch comes from address 0.
    step(0, 1, 1, 0, 12'h000, 12'h001, 19'h00100, 12'h001, 1, 16'd0, 16'd1);

    // Long stall of the PC with PR1 still loading: both counters saturate.
    step(0, 0, 1, 0, 12'h000, 12'h001, 19'h00101, 12'h002, 1, 16'd1, 16'd2);
    repeat (65532) @(negedge clk);
    step(0, 0, 1, 0, 12'h000, 12'h001, 19'h00101, 12'h002, 1, 16'hFFFE, 16'hFFFF);
    step(0, 0, 1, 0, 12'h000, 12'h001, 19'h00101, 12'h002, 1, 16'hFFFF, 16'hFFFF);
    repeat (4) @(negedge clk);
    step(0, 0, 1, 0, 12'h000, 12'h001, 19'h00101, 12'h002, 1, 16'hFFFF, 16'hFFFF);

    repeat (3) @(negedge clk);
    chk("queue_drained", 0, exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register (PR1) of the 19-bit, 8-register pipelined processor.
- Holds the PC and drives the instruction-memory address.
- Captures the fetched word into PR1 and decodes register fields for the load-use hazard unit downstream.
- Applies the hazard unit's PC/PR1 write enables (stall) and the execute stage's redirect (flush).
- Keeps stall and retired-fetch performance counters.

Parameters:
- PC_W, 12, PC and instruction-memory address width.
- INSTR_W, 19, instruction width.
- NOP_INSTR, 19'h0E000, bubble word loaded into PR1 on flush/reset; its opcode is outside every hazard-checked class.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- PC_write_en  input  1  from hazard unit; 0 holds the PC
- PR1_IF_ID_write_en  input  1  from hazard unit; 0 holds PR1
- branch_taken  input  1  redirect request from execute stage
- branch_target  input  PC_W  redirect address
- inst_mem_data  input  INSTR_W  combinational read data at inst_mem_addr
- inst_mem_addr  output  PC_W  current PC
- PR1_instruction  output  INSTR_W  registered instruction
- PR1_PC_plus1  output  PC_W  registered PC+1 of that instruction
- PR1_valid  output  1  1 = PR1 holds a real instruction, 0 = bubble
- PR1_opcode  output  5  PR1_instruction[18:14]
- PR1_rd  output  3  PR1_instruction[13:11]
- PR1_rs  output  3  PR1_instruction[10:8]
- PR1_rt  output  3  PR1_instruction[7:5]
- stall_count  output  CNT_W  cycles with PC_write_en=0 and no redirect, saturating
- fetch_count  output  CNT_W  instructions accepted into PR1 with valid=1, saturating

Behaviour:
- Reset, asynchronous and immediate:
  - PC = 0.
  - PR1_instruction = NOP_INSTR, PR1_PC_plus1 = 0, PR1_valid = 0.
  - Both counters = 0.
- Field outputs are purely combinational slices of PR1_instruction. The bubble therefore shows NOP_INSTR fields.
- inst_mem_addr = PC, combinational. Memory data is consumed in the same cycle, so fetch-to-PR1 latency is 1 cycle.
- PC update, priority order each rising edge:
  1. branch_taken → PC = branch_target.
  2. else PC_write_en → PC = PC+1, modulo 2^PC_W. 4095 wraps to 0 with no flag.
  3. else hold.
- PR1 update, priority order:
  1. branch_taken → flush. Load NOP_INSTR, PR1_PC_plus1 = 0, PR1_valid = 0.
  2. else PR1_IF_ID_write_en → load inst_mem_data, PC+1 (wrapped), PR1_valid = 1.
  3. else hold all PR1 fields, including valid.
- Redirect beats stall: the stalled instruction is wrong-path. branch_taken=1 with both enables 0 still redirects and flushes.
- Mismatched enables (PC_write_en ≠ PR1_IF_ID_write_en) are legal. Each register obeys its own enable. No consistency checking.
- stall_count increments when PC_write_en=0 and branch_taken=0. Saturates at all-ones.
- fetch_count increments when PR1 loads with valid=1 (branch_taken=0 and PR1_IF_ID_write_en=1). Saturates at all-ones.
- Reset asserted mid-stall or mid-redirect: every register returns to its reset value immediately. The first fetch after deassertion is from address 0.
- No other internal state. The block has two implicit states, RUN and STALL, selected per cycle by the enables. Nothing persists beyond the registers listed.

Test Plan:
- Reset release, enables=1, memory word n = 19'h00100+n → inst_mem_addr 0,1,2…; one cycle later PR1_instruction = 19'h00100, PR1_PC_plus1 = 1, PR1_valid = 1; fetch_count = 3 after 3 edges.
- Steady fetch at PC=5, drive both enables 0 for 2 cycles → PC stays 5; PR1 keeps the PC=4 instruction; stall_count = 2; then resumes with PC 6.
- Stall held and branch_taken=1, branch_target=12'h3A0 in the same cycle → next PC = 12'h3A0; PR1 = NOP_INSTR, PR1_valid = 0; stall_count unchanged; fetch_count unchanged.
- PC forced to 12'hFFF via redirect, then free-run → PR1_PC_plus1 = 0, PC = 0 next; no other side effect.
- Assert rst during a stall with PC=7 and counters nonzero → outputs reset asynchronously, before the next edge; after release first inst_mem_addr = 0.
- Run > 65535 stall cycles → stall_count holds at 16'hFFFF.
